// File: rtl/forth_irq_ctrl_if.sv
// Core-side bus of the ForthCPU interrupt controller: request/ack/return
// handshake plus the small configuration register port.
interface forth_irq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             interrupt;
    logic [WIDTH-1:0] irq_vector;
    logic             interrupt_ack;
    logic             reti;
    logic             in_service;
    logic             cfg_we;
    logic             cfg_re;
    logic [1:0]       cfg_addr;
    logic [WIDTH-1:0] cfg_wdata;
    logic [WIDTH-1:0] cfg_rdata;

    modport master (
        input  interrupt, irq_vector, in_service, cfg_rdata,
        output interrupt_ack, reti, cfg_we, cfg_re, cfg_addr, cfg_wdata
    );

    modport slave (
        output interrupt, irq_vector, in_service, cfg_rdata,
        input  interrupt_ack, reti, cfg_we, cfg_re, cfg_addr, cfg_wdata
    );
endinterface

// File: rtl/forth_irq_ctrl.sv
// Interrupt controller for the ForthCPU core: edge capture, fixed-priority
// arbitration (lowest index wins), request/ack/reti sequencing, config regs.
//
// state   | meaning
// IDLE    | no request outstanding; arbitrate enabled pending events
// REQUEST | interrupt=1, index/vector frozen until ack or withdrawal
// SERVICE | handler running; no nesting until reti
module forth_irq_ctrl #(
    parameter int               WIDTH        = 16,
    parameter int               NUM_IRQ      = 8,
    parameter logic [WIDTH-1:0] VECTOR_BASE  = 16'h0010,
    parameter int               VECTOR_SHIFT = 2
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               hlt,
    input  logic               wfi,
    forth_irq_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

    state_t             state, state_nxt;
    logic [NUM_IRQ-1:0] sync1, sync2, hist, rise;
    logic [NUM_IRQ-1:0] pending, mask, w1c, mask_wd, pend_wd, sel_oh, ack_clr;
    logic [WIDTH-1:0]   vector_base;
    logic [3:0]         index, pick;
    logic               any_req, load_vec;
    logic               wr_mask, wr_pend, wr_base;

    // Capture flops reset high so a line already high at reset release is not an edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync1 <= '1;
            sync2 <= '1;
            hist  <= '1;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise    = sync2 & ~hist;
    assign wr_mask = bus.cfg_we && (bus.cfg_addr == 2'd0);
    assign wr_pend = bus.cfg_we && (bus.cfg_addr == 2'd1);
    assign wr_base = bus.cfg_we && (bus.cfg_addr == 2'd2);
    assign w1c     = wr_pend ? bus.cfg_wdata[NUM_IRQ-1:0] : '0;
    assign mask_wd = wr_mask ? bus.cfg_wdata[NUM_IRQ-1:0] : mask;
    assign pend_wd = (pending & ~w1c) | rise;
    assign sel_oh  = NUM_IRQ'(1) << index;
    assign any_req = |(pending & mask);

    always_comb begin
        pick = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i] && mask[i]) pick = 4'(i);
        end
    end

    // Withdrawal looks at the register values this edge will produce, so a
    // write that disables the request drops interrupt on the same edge.
    always_comb begin
        state_nxt = state;
        ack_clr   = '0;
        load_vec  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req && !hlt) begin
                    state_nxt = REQUEST;
                    load_vec  = 1'b1;
                end
            end
            REQUEST: begin
                if (hlt || !(|(pend_wd & sel_oh)) || !(|(mask_wd & sel_oh))) begin
                    state_nxt = IDLE;
                end else if (bus.interrupt_ack) begin
                    state_nxt = SERVICE;
                    ack_clr   = sel_oh;
                end
            end
            SERVICE: begin
                if (bus.reti) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.interrupt  = (state == REQUEST);
    assign bus.in_service = (state == SERVICE);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state          <= IDLE;
            pending        <= '0;
            mask           <= '0;
            vector_base    <= VECTOR_BASE;
            index          <= '0;
            bus.irq_vector <= '0;
            bus.cfg_rdata  <= '0;
        end else begin
            state   <= state_nxt;
            pending <= (pending & ~w1c & ~ack_clr) | rise;
            if (wr_mask) mask <= bus.cfg_wdata[NUM_IRQ-1:0];
            if (wr_base) vector_base <= bus.cfg_wdata;
            if (load_vec) begin
                index          <= pick;
                bus.irq_vector <= vector_base + (WIDTH'(pick) << VECTOR_SHIFT);
            end
            if (bus.cfg_re) begin
                case (bus.cfg_addr)
                    2'd0:    bus.cfg_rdata <= WIDTH'(mask);
                    2'd1:    bus.cfg_rdata <= WIDTH'(pending);
                    2'd2:    bus.cfg_rdata <= vector_base;
                    default: bus.cfg_rdata <= WIDTH'({index, 1'b0, wfi,
                                                      bus.in_service, bus.interrupt});
                endcase
            end
        end
    end
endmodule

// File: tb/tb_forth_irq_ctrl.sv
// Bench for forth_irq_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_forth_irq_ctrl;
    localparam int W = 16;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic [N-1:0] irq_in = '0;
    logic         hlt = 1'b0;
    logic         wfi = 1'b0;
    logic [15:0]  rd;

    forth_irq_ctrl_if #(.WIDTH(W)) bus ();

    forth_irq_ctrl #(
        .WIDTH(W), .NUM_IRQ(N), .VECTOR_BASE(16'h0010), .VECTOR_SHIFT(2)
    ) dut (
        .clk(clk), .nreset(nreset), .irq_in(irq_in), .hlt(hlt), .wfi(wfi),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: three-sample input history, pending/mask/base
    // registers, and request/service flags.
    logic [N-1:0] m_pend, m_mask, s0, s1, s2;
    logic [N-1:0] m_rise, m_w1c, m_pend_w, m_mask_w, m_clr;
    logic [15:0]  m_vb, m_vb_w, m_vec, m_rdata;
    int           m_idx;
    bit           m_req, m_svc;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_pend = '0; m_mask = '0; m_vb = 16'h0010; m_vec = '0; m_rdata = '0;
            m_idx = 0; m_req = 0; m_svc = 0;
            s0 = '1; s1 = '1; s2 = '1;
        end else begin
            m_rise = s1 & ~s2;
            if (bus.cfg_re) begin
                case (bus.cfg_addr)
                    2'd0:    m_rdata = {8'h00, m_mask};
                    2'd1:    m_rdata = {8'h00, m_pend};
                    2'd2:    m_rdata = m_vb;
                    default: m_rdata = {8'h00, 4'(m_idx), 1'b0, wfi, m_svc, m_req};
                endcase
            end
            m_w1c    = (bus.cfg_we && bus.cfg_addr == 2'd1) ? bus.cfg_wdata[7:0] : '0;
            m_mask_w = (bus.cfg_we && bus.cfg_addr == 2'd0) ? bus.cfg_wdata[7:0] : m_mask;
            m_vb_w   = (bus.cfg_we && bus.cfg_addr == 2'd2) ? bus.cfg_wdata : m_vb;
            m_pend_w = (m_pend & ~m_w1c) | m_rise;
            m_clr    = '0;
            if (m_req) begin
                if (hlt || !m_pend_w[m_idx] || !m_mask_w[m_idx]) begin
                    m_req = 0;
                end else if (bus.interrupt_ack) begin
                    m_req = 0;
                    m_svc = 1;
                    m_clr[m_idx] = 1'b1;
                end
            end else if (m_svc) begin
                if (bus.reti) m_svc = 0;
            end else if ((m_pend & m_mask) != 0 && !hlt) begin
                for (int i = 0; i < N; i++) begin
                    if (m_pend[i] && m_mask[i]) begin
                        m_idx = i;
                        break;
                    end
                end
                m_vec = m_vb + 16'(m_idx * 4);
                m_req = 1;
            end
            m_pend = (m_pend & ~m_w1c & ~m_clr) | m_rise;
            m_mask = m_mask_w;
            m_vb   = m_vb_w;
            s2 = s1; s1 = s0; s0 = irq_in;
        end
    end

    always @(negedge clk) begin
        if (nreset) begin
            check("interrupt", 32'(bus.interrupt), 32'(m_req));
            check("in_service", 32'(bus.in_service), 32'(m_svc));
            if (m_req || m_svc) check("irq_vector", 32'(bus.irq_vector), 32'(m_vec));
            check("cfg_rdata", 32'(bus.cfg_rdata), 32'(m_rdata));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [15:0] data);
        bus.cfg_we = 1'b1; bus.cfg_addr = addr; bus.cfg_wdata = data;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] addr, output logic [15:0] data);
        bus.cfg_re = 1'b1; bus.cfg_addr = addr;
        tick();
        bus.cfg_re = 1'b0;
        data = bus.cfg_rdata;
    endtask

    task automatic ack_pulse();
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
    endtask

    task automatic reti_pulse();
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
    endtask

    task automatic wait_int(input string name);
        int n = 0;
        while (!bus.interrupt && n < 20) begin
            tick();
            n++;
        end
        check({name, " wait interrupt"}, 32'(bus.interrupt), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        bus.interrupt_ack = 0; bus.reti = 0; bus.cfg_we = 0; bus.cfg_re = 0;
        bus.cfg_addr = '0; bus.cfg_wdata = '0;
        repeat (3) tick();
        check("reset interrupt", 32'(bus.interrupt), 0);
        check("reset in_service", 32'(bus.in_service), 0);
        check("reset irq_vector", 32'(bus.irq_vector), 0);
        check("reset cfg_rdata", 32'(bus.cfg_rdata), 0);
        nreset = 1'b1;
        tick();

        // Basic capture, latency, ack and return.
        cfg_write(2'd0, 16'h0005);
        irq_in[2] = 1'b1;
        repeat (3) tick();
        check("s1 no request before arbitration", 32'(bus.interrupt), 0);
        cfg_read(2'd1, rd);
        check("s1 pending", 32'(rd), 32'h0004);
        check("s1 interrupt", 32'(bus.interrupt), 1);
        check("s1 vector", 32'(bus.irq_vector), 32'h0018);
        irq_in[2] = 1'b0;
        ack_pulse();
        check("s1 ack interrupt", 32'(bus.interrupt), 0);
        check("s1 ack in_service", 32'(bus.in_service), 1);
        cfg_read(2'd1, rd);
        check("s1 pending cleared", 32'(rd), 0);
        reti_pulse();
        check("s1 reti in_service", 32'(bus.in_service), 0);

        // Priority between simultaneous events.
        cfg_write(2'd0, 16'h00FF);
        irq_in = 8'h22;
        wait_int("s2a");
        check("s2 first vector", 32'(bus.irq_vector), 32'h0014);
        ack_pulse();
        irq_in = '0;
        reti_pulse();
        wait_int("s2b");
        check("s2 second vector", 32'(bus.irq_vector), 32'h0024);
        ack_pulse();
        reti_pulse();

        // No nesting during service.
        irq_in[1] = 1'b1;
        wait_int("s3a");
        check("s3 vector 1", 32'(bus.irq_vector), 32'h0014);
        ack_pulse();
        irq_in[1] = 1'b0;
        irq_in[0] = 1'b1;
        repeat (2) tick();
        irq_in[0] = 1'b0;
        repeat (6) tick();
        check("s3 no nesting", 32'(bus.interrupt), 0);
        cfg_read(2'd3, rd);
        check("s3 status in_service", 32'(rd[1]), 1);
        check("s3 status index", 32'(rd[7:4]), 1);
        reti_pulse();
        wait_int("s3b");
        check("s3 vector 0", 32'(bus.irq_vector), 32'h0010);
        ack_pulse();
        reti_pulse();

        // Withdrawal by masking, then reissue.
        irq_in[3] = 1'b1;
        wait_int("s4a");
        check("s4 vector", 32'(bus.irq_vector), 32'h001C);
        cfg_write(2'd0, 16'h0000);
        check("s4 withdrawn", 32'(bus.interrupt), 0);
        cfg_read(2'd1, rd);
        check("s4 pending kept", 32'(rd), 32'h0008);
        cfg_write(2'd0, 16'h0008);
        wait_int("s4b");
        check("s4 reissued vector", 32'(bus.irq_vector), 32'h001C);
        irq_in[3] = 1'b0;
        ack_pulse();
        reti_pulse();

        // Halt hold-off, relocated vector base, then async reset mid-service.
        hlt = 1'b1;
        cfg_write(2'd2, 16'h8000);
        cfg_write(2'd0, 16'h0080);
        irq_in[7] = 1'b1;
        repeat (8) tick();
        check("s5 halted", 32'(bus.interrupt), 0);
        hlt = 1'b0;
        wait_int("s5");
        check("s5 vector", 32'(bus.irq_vector), 32'h801C);
        ack_pulse();
        check("s5 in_service", 32'(bus.in_service), 1);
        @(posedge clk);
        #3;
        nreset = 1'b0;
        #1;
        check("s6 async interrupt", 32'(bus.interrupt), 0);
        check("s6 async in_service", 32'(bus.in_service), 0);
        check("s6 async vector", 32'(bus.irq_vector), 0);
        check("s6 async rdata", 32'(bus.cfg_rdata), 0);
        tick();
        nreset = 1'b1;
        repeat (10) tick();
        cfg_read(2'd0, rd);
        check("s6 mask reset", 32'(rd), 0);
        cfg_read(2'd2, rd);
        check("s6 base reset", 32'(rd), 32'h0010);
        cfg_read(2'd1, rd);
        check("s6 no event from held line", 32'(rd), 0);
        cfg_write(2'd0, 16'h00FF);
        repeat (5) tick();
        check("s6 no request", 32'(bus.interrupt), 0);
        irq_in = '0;
        repeat (4) tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            r = $urandom & $urandom & $urandom;
            irq_in = irq_in ^ r[7:0];
            hlt = ($urandom_range(0, 9) == 0);
            wfi = $urandom_range(0, 1);
            bus.interrupt_ack = bus.interrupt ? ($urandom_range(0, 2) == 0)
                                              : ($urandom_range(0, 19) == 0);
            bus.reti = bus.in_service ? ($urandom_range(0, 3) == 0)
                                      : ($urandom_range(0, 19) == 0);
            bus.cfg_we = ($urandom_range(0, 7) == 0);
            bus.cfg_re = ($urandom_range(0, 2) == 0);
            bus.cfg_addr = 2'($urandom_range(0, 3));
            r = $urandom;
            bus.cfg_wdata = r[15:0];
            if (bus.cfg_we && bus.cfg_addr == 2'd0 && r[16]) bus.cfg_wdata[7:0] = 8'hFF;
            tick();
        end
        bus.interrupt_ack = 0; bus.reti = 0; bus.cfg_we = 0; bus.cfg_re = 0; hlt = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
